// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Holds reset/exception vectors, bus widths, IF/ID field offsets and state encoding.
package fetch_pkg;

    localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
    localparam logic [31:0] EXC_ENTER_ADDR = 32'hBFC0_0380;

    localparam int IF_ID_BUS_W = 66;
    localparam int JBR_BUS_W   = 34;
    localparam int EXC_BUS_W   = 33;

    // IF_ID_bus = {pc[31:0], inst[31:0], fetch_error, delay_slot}
    localparam int IFID_PC_LSB   = 34;
    localparam int IFID_INST_LSB = 2;
    localparam int IFID_FERR_BIT = 1;
    localparam int IFID_DS_BIT   = 0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous ROM and
// hands {pc, inst, fetch_error, delay_slot} to decode.
// Ports: clk, reset (sync, active-high), ID_allow_in, jbr_bus, exc_bus, cancel,
//        inst_addr/inst_rdata (ROM), IF_over, IF_ID_bus, IF_pc.
module fetch
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_allow_in,
    input  logic [JBR_BUS_W-1:0]   jbr_bus,
    input  logic [EXC_BUS_W-1:0]   exc_bus,
    input  logic                   cancel,
    output logic [31:0]            inst_addr,
    input  logic [31:0]            inst_rdata,
    output logic                   IF_over,
    output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
    output logic [31:0]            IF_pc
);

    logic        br_leave;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_pc;

    assign {br_leave, br_taken, br_target} = jbr_bus;
    assign {exc_valid, exc_pc}             = exc_bus;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ds_pend_q, ds_pend_d;
    logic         tgt_pend_q, tgt_pend_d;
    logic [31:0]  tgt_pc_q, tgt_pc_d;

    logic run;
    logic kill;
    logic handoff;
    logic fetch_error;

    assign run         = (state_q == ST_RUN);
    assign kill        = exc_valid | cancel;
    assign handoff     = run & ID_allow_in & ~kill;
    assign fetch_error = |pc_q[1:0];

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        ds_pend_d  = ds_pend_q;
        tgt_pend_d = tgt_pend_q;
        tgt_pc_d   = tgt_pc_q;

        // BOOT keeps the PC so the ROM word requested during BOOT matches it.
        if (run) begin
            if (exc_valid)
                pc_d = exc_pc;
            else if (handoff && br_leave && br_taken)
                pc_d = br_target;
            else if (handoff && ds_pend_q && tgt_pend_q)
                pc_d = tgt_pc_q;
            else if (handoff)
                pc_d = pc_q + 32'd4;
        end

        if (kill || handoff) begin
            ds_pend_d  = 1'b0;
            tgt_pend_d = 1'b0;
        end else if (run && br_leave) begin
            // Branch left decode while we stall: remember slot and target.
            ds_pend_d = 1'b1;
            if (br_taken) begin
                tgt_pend_d = 1'b1;
                tgt_pc_d   = br_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            ds_pend_q  <= 1'b0;
            tgt_pend_q <= 1'b0;
            tgt_pc_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ds_pend_q  <= ds_pend_d;
            tgt_pend_q <= tgt_pend_d;
            tgt_pc_q   <= tgt_pc_d;
        end
    end

    // ROM address tracks next-PC so next cycle's data belongs to the new pc.
    assign inst_addr = run ? pc_d : RESET_PC;
    assign IF_over   = run & ~kill;
    assign IF_pc     = pc_q;

    assign IF_ID_bus[IFID_PC_LSB +: 32]   = pc_q;
    assign IF_ID_bus[IFID_INST_LSB +: 32] = fetch_error ? 32'd0 : inst_rdata;
    assign IF_ID_bus[IFID_FERR_BIT]       = fetch_error;
    assign IF_ID_bus[IFID_DS_BIT]         = ds_pend_q | br_leave;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage.
// Directed test-plan sequence followed by randomized traffic against a reference model.
module tb_fetch;
    import fetch_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ID_allow_in;
    logic [JBR_BUS_W-1:0]   jbr_bus;
    logic [EXC_BUS_W-1:0]   exc_bus;
    logic                   cancel;
    logic [31:0]            inst_addr;
    logic [31:0]            inst_rdata;
    logic                   IF_over;
    logic [IF_ID_BUS_W-1:0] IF_ID_bus;
    logic [31:0]            IF_pc;

    int checks = 0;
    int errors = 0;

    fetch dut (
        .clk        (clk),
        .reset      (reset),
        .ID_allow_in(ID_allow_in),
        .jbr_bus    (jbr_bus),
        .exc_bus    (exc_bus),
        .cancel     (cancel),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .IF_pc      (IF_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) inst_rdata <= rom(inst_addr);

    task automatic chk(input string tag, input logic [65:0] obs,
                       input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: program-order view of what decode should receive.
    bit          m_run = 1'b0;
    logic [31:0] m_pc  = RESET_PC;
    bit          m_ds  = 1'b0;
    logic [31:0] m_tq[$];

    task automatic cycle(input bit rst, input bit allow, input bit brl,
                         input bit brt, input logic [31:0] tgt,
                         input bit exc, input logic [31:0] epc,
                         input bit cnl);
        bit          eo;
        bit          ho;
        bit          ferr;
        logic [31:0] nxt;
        logic [65:0] eb;
        @(negedge clk);
        reset       = rst;
        ID_allow_in = allow;
        jbr_bus     = {brl, brt, tgt};
        exc_bus     = {exc, epc};
        cancel      = cnl;
        #1;
        eo = m_run && !(exc || cnl);
        ho = eo && allow;
        if (!m_run)
            nxt = m_pc;
        else if (exc)
            nxt = epc;
        else if (ho && brl && brt)
            nxt = tgt;
        else if (ho && m_ds && m_tq.size() > 0)
            nxt = m_tq[0];
        else if (ho)
            nxt = m_pc + 32'd4;
        else
            nxt = m_pc;
        if (!rst) begin
            chk("if_over", {65'd0, IF_over}, {65'd0, eo});
            chk("if_pc", {34'd0, IF_pc}, {34'd0, m_pc});
            chk("inst_addr", {34'd0, inst_addr},
                {34'd0, m_run ? nxt : RESET_PC});
            if (eo) begin
                ferr = (m_pc[1:0] != 2'b00);
                eb = {m_pc, ferr ? 32'd0 : rom(m_pc), ferr, m_ds || brl};
                chk("if_id_bus", eb, IF_ID_bus);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0;
            m_pc  = RESET_PC;
            m_ds  = 1'b0;
            m_tq.delete();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (exc || cnl || ho) begin
                m_ds = 1'b0;
                m_tq.delete();
            end else if (brl) begin
                m_ds = 1'b1;
                if (brt) m_tq.push_back(tgt);
            end
            m_pc = nxt;
        end
    endtask

    task automatic step(input bit allow);
        cycle(1'b0, allow, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic branch(input bit allow, input logic [31:0] tgt);
        cycle(1'b0, allow, 1'b1, 1'b1, tgt, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic raise(input bit allow, input logic [31:0] epc);
        cycle(1'b0, allow, 1'b0, 1'b0, 32'd0, 1'b1, epc, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic pc_is(input string tag, input logic [31:0] v);
        #1;
        chk(tag, {34'd0, IF_pc}, {34'd0, v});
    endtask

    initial begin
        reset       = 1'b1;
        ID_allow_in = 1'b0;
        jbr_bus     = '0;
        exc_bus     = '0;
        cancel      = 1'b0;

        // Sequential fetch with a 3-cycle stall at BFC00008.
        do_reset();
        pc_is("reset_pc", RESET_PC);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        pc_is("seq_pc", 32'hBFC0_0008);
        repeat (3) step(1'b0);
        pc_is("stall_pc", 32'hBFC0_0008);
        step(1'b1);
        step(1'b1);
        pc_is("resume_pc", 32'hBFC0_0010);

        // Branch leaving with the delay-slot handoff at BFC00004.
        do_reset();
        step(1'b1);
        step(1'b1);
        branch(1'b1, 32'hBFC0_0100);
        pc_is("br_tgt", 32'hBFC0_0100);

        // Branch leaving during a stall.
        step(1'b1);
        branch(1'b0, 32'h8000_0040);
        step(1'b0);
        step(1'b1);
        pc_is("br_stall_tgt", 32'h8000_0040);

        // Exception during a stall with a branch pending.
        step(1'b1);
        branch(1'b0, 32'hBFC0_0200);
        raise(1'b0, EXC_ENTER_ADDR);
        pc_is("exc_pc", EXC_ENTER_ADDR);
        step(1'b1);
        pc_is("exc_next", EXC_ENTER_ADDR + 32'd4);

        // Misaligned redirect produces a fetch error, then pc+4.
        raise(1'b1, 32'hBFC0_0382);
        step(1'b1);
        pc_is("ferr_next", 32'hBFC0_0386);

        // Cancel holds pc and drops a pending branch.
        branch(1'b0, 32'h1234_5678);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step(1'b1);
        pc_is("cancel_pc", 32'hBFC0_038A);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          rst;
            bit          al;
            bit          bl;
            bit          bt;
            bit          ex;
            bit          cn;
            logic [31:0] tg;
            logic [31:0] ep;
            rst = ($urandom_range(0, 99) == 0);
            al  = ($urandom_range(0, 3) != 0);
            bl  = m_run && !m_ds && ($urandom_range(0, 4) == 0);
            bt  = $urandom_range(0, 1) == 1;
            ex  = ($urandom_range(0, 29) == 0);
            cn  = ($urandom_range(0, 29) == 0);
            tg  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ;
            ep  = $urandom;
            if ($urandom_range(0, 3) != 0) ep[1:0] = 2'b00;
            cycle(rst, al, bl, bt, tg, ex, ep, cn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
